trigger_conditioner: RTL and testbench

- Front-end stage directly upstream of signal_generator on the ui_in[3] trigger path.
- Synchronises the asynchronous trigger pin and glitch-filters it with a programmable qualification length.
- Produces a clean level plus single-cycle edge and trigger pulses.
- Captures a timestamp from the free-running counter on qualified edges and holds it for the register map behind a valid/ack handshake.

---
 rtl/trigger_conditioner_if.sv | 20 ++
 rtl/trigger_conditioner.sv | 124 ++++++++++++
 tb/tb_trigger_conditioner.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/trigger_conditioner_if.sv
// Timestamp hand-off between trigger_conditioner (master) and the register map (slave).
interface trigger_conditioner_if #(
  parameter int CNT_WIDTH = 32
);
  logic                 ts_valid;
  logic [CNT_WIDTH-1:0] ts_data;
  logic                 ts_is_rising;
  logic                 ts_overflow;
  logic                 ts_ack;

  modport master (
    output ts_valid, ts_data, ts_is_rising, ts_overflow,
    input  ts_ack
  );

  modport slave (
    input  ts_valid, ts_data, ts_is_rising, ts_overflow,
    output ts_ack
  );
endinterface

// File: rtl/trigger_conditioner.sv
// Synchronises and glitch-filters the trigger pin, emits edge/trigger pulses and
// captures a timestamp on qualified edges behind a valid/ack handshake.
module trigger_conditioner #(
  parameter int CNT_WIDTH  = 32,
  parameter int FILT_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  trigger_in,
  input  logic [FILT_WIDTH-1:0] filt_len,
  input  logic [CNT_WIDTH-1:0]  counter,
  input  logic                  is_trigger_on_rising_edge,
  input  logic                  is_trigger_on_falling_edge,
  input  logic                  is_save_rising_timestamp,
  input  logic                  is_save_falling_timestamp,
  output logic                  trig_level,
  output logic                  rise_pulse,
  output logic                  fall_pulse,
  output logic                  trig_pulse,
  trigger_conditioner_if.master ts
);

  typedef enum logic {
    STABLE,
    QUALIFY
  } state_t;

  state_t                state, state_nx;
  logic                  sync1, sync2;
  logic [FILT_WIDTH-1:0] run_cnt, run_cnt_nx;
  logic                  level_nx;
  logic                  accept;
  logic                  capture;

  always_comb begin
    state_nx   = state;
    run_cnt_nx = run_cnt;
    level_nx   = trig_level;
    accept     = 1'b0;
    unique case (state)
      STABLE: begin
        if (sync2 == trig_level) begin
          run_cnt_nx = '0;
          state_nx   = STABLE;
        end else if (run_cnt < filt_len) begin
          run_cnt_nx = run_cnt + 1'b1;
          state_nx   = QUALIFY;
        end else begin
          accept     = 1'b1;
          level_nx   = sync2;
          run_cnt_nx = '0;
          state_nx   = STABLE;
        end
      end
      QUALIFY: begin
        // Input fell back before qualifying: the glitch is dropped silently.
        if (sync2 == trig_level) begin
          run_cnt_nx = '0;
          state_nx   = STABLE;
        end else if (run_cnt < filt_len) begin
          run_cnt_nx = run_cnt + 1'b1;
          state_nx   = QUALIFY;
        end else begin
          accept     = 1'b1;
          level_nx   = sync2;
          run_cnt_nx = '0;
          state_nx   = STABLE;
        end
      end
      default: begin
        run_cnt_nx = '0;
        state_nx   = STABLE;
      end
    endcase
  end

  assign capture = accept && (sync2 ? is_save_rising_timestamp : is_save_falling_timestamp);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      state      <= STABLE;
      run_cnt    <= '0;
      trig_level <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      trig_pulse <= 1'b0;
    end else begin
      sync1      <= trigger_in;
      sync2      <= sync1;
      state      <= state_nx;
      run_cnt    <= run_cnt_nx;
      trig_level <= level_nx;
      rise_pulse <= accept && sync2;
      fall_pulse <= accept && !sync2;
      trig_pulse <= accept && ((sync2 && is_trigger_on_rising_edge) ||
                               (!sync2 && is_trigger_on_falling_edge));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ts.ts_valid     <= 1'b0;
      ts.ts_data      <= '0;
      ts.ts_is_rising <= 1'b0;
      ts.ts_overflow  <= 1'b0;
    end else if (capture) begin
      // An ack on the same edge frees the slot, so the new capture wins.
      if (!ts.ts_valid || ts.ts_ack) begin
        ts.ts_valid     <= 1'b1;
        ts.ts_data      <= counter;
        ts.ts_is_rising <= sync2;
        if (ts.ts_ack) ts.ts_overflow <= 1'b0;
      end else begin
        ts.ts_overflow <= 1'b1;
      end
    end else if (ts.ts_ack && ts.ts_valid) begin
      ts.ts_valid    <= 1'b0;
      ts.ts_overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_trigger_conditioner.sv
// Directed scenarios plus randomized traffic against a streak-counting reference model.
module tb_trigger_conditioner;

  logic        clk = 1'b0;
  logic        rst;
  logic        trigger_in;
  logic [3:0]  filt_len;
  logic [31:0] counter;
  logic        en_r, en_f, save_r, save_f;
  logic        trig_level, rise_pulse, fall_pulse, trig_pulse;

  trigger_conditioner_if #(.CNT_WIDTH(32)) ts_if ();

  trigger_conditioner #(
    .CNT_WIDTH (32),
    .FILT_WIDTH(4)
  ) dut (
    .clk                       (clk),
    .rst                       (rst),
    .trigger_in                (trigger_in),
    .filt_len                  (filt_len),
    .counter                   (counter),
    .is_trigger_on_rising_edge (en_r),
    .is_trigger_on_falling_edge(en_f),
    .is_save_rising_timestamp  (save_r),
    .is_save_falling_timestamp (save_f),
    .trig_level                (trig_level),
    .rise_pulse                (rise_pulse),
    .fall_pulse                (fall_pulse),
    .trig_pulse                (trig_pulse),
    .ts                        (ts_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Reference model: the pin reaches the filter two samples late, and the level
  // flips once filt_len+1 consecutive samples disagree with it.
  logic        m_s1, m_s2;
  int          streak;
  logic        e_level, e_rise, e_fall, e_trig;
  logic        e_valid, e_isr, e_ovf;
  logic [31:0] e_data;

  task automatic model_edge();
    logic acc, cap;
    if (rst) begin
      m_s1 = 0; m_s2 = 0; streak = 0;
      e_level = 0; e_rise = 0; e_fall = 0; e_trig = 0;
      e_valid = 0; e_isr = 0; e_ovf = 0; e_data = '0;
      return;
    end
    acc = 0;
    if (m_s2 != e_level) begin
      streak++;
      if (streak >= int'(filt_len) + 1) begin
        acc = 1;
        streak = 0;
      end
    end else begin
      streak = 0;
    end
    e_rise = acc && m_s2;
    e_fall = acc && !m_s2;
    e_trig = (e_rise && en_r) || (e_fall && en_f);
    cap    = acc && (m_s2 ? save_r : save_f);
    if (cap) begin
      if (!e_valid || ts_if.ts_ack) begin
        e_data  = counter;
        e_isr   = m_s2;
        e_valid = 1;
        e_ovf   = 0;
      end else begin
        e_ovf = 1;
      end
    end else if (ts_if.ts_ack && e_valid) begin
      e_valid = 0;
      e_ovf   = 0;
    end
    if (acc) e_level = m_s2;
    m_s2 = m_s1;
    m_s1 = trigger_in;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("trig_level", trig_level, e_level);
    check("rise_pulse", rise_pulse, e_rise);
    check("fall_pulse", fall_pulse, e_fall);
    check("trig_pulse", trig_pulse, e_trig);
    check("ts_valid", ts_if.ts_valid, e_valid);
    check("ts_data", ts_if.ts_data, e_data);
    check("ts_is_rising", ts_if.ts_is_rising, e_isr);
    check("ts_overflow", ts_if.ts_overflow, e_ovf);
  endtask

  int n_rise, n_trig;

  task automatic drive(input logic v, input int n);
    trigger_in = v;
    repeat (n) begin
      step();
      n_rise += int'(rise_pulse);
      n_trig += int'(trig_pulse);
    end
  endtask

  initial begin
    int n, hold;
    rst = 1; trigger_in = 0; filt_len = 0; counter = '0;
    en_r = 0; en_f = 0; save_r = 0; save_f = 0; ts_if.ts_ack = 0;
    repeat (3) step();
    check("reset_level", trig_level, 0);
    check("reset_valid", ts_if.ts_valid, 0);
    rst = 0;

    // filt_len=0: acceptance on the third edge after the pin changes
    save_r = 1; en_r = 1; counter = 100;
    drive(0, 5);
    trigger_in = 1;
    step(); step();
    check("t1_level_early", trig_level, 0);
    step();
    check("t1_level", trig_level, 1);
    check("t1_rise", rise_pulse, 1);
    check("t1_ts_valid", ts_if.ts_valid, 1);
    check("t1_ts_data", ts_if.ts_data, 100);
    check("t1_ts_rising", ts_if.ts_is_rising, 1);
    step();
    check("t1_rise_one_cycle", rise_pulse, 0);
    ts_if.ts_ack = 1; step(); ts_if.ts_ack = 0;
    drive(0, 6);

    // filt_len=3: a 3-cycle pulse is a glitch, a 4-cycle pulse qualifies at k+5
    filt_len = 3; n_rise = 0;
    drive(1, 3);
    drive(0, 10);
    check("t2_glitch_rise", n_rise, 0);
    check("t2_glitch_level", trig_level, 0);
    trigger_in = 1; n = 0;
    do begin
      step();
      n++;
    end while (!trig_level && n < 20);
    check("t2_latency", n, 6);
    drive(1, 1);
    drive(0, 12);

    // Both trigger edges enabled, only falling saved
    filt_len = 0; en_r = 1; en_f = 1; save_r = 0; save_f = 1;
    ts_if.ts_ack = 1; step(); ts_if.ts_ack = 0;
    counter = 32'h3333; n_trig = 0;
    drive(1, 6);
    drive(0, 6);
    check("t3_trig_count", n_trig, 2);
    check("t3_valid", ts_if.ts_valid, 1);
    check("t3_rising", ts_if.ts_is_rising, 0);
    check("t3_data", ts_if.ts_data, 32'h3333);

    // Second capture while held: dropped, overflow set
    counter = 32'h4444;
    drive(1, 5);
    drive(0, 5);
    check("t4_data_kept", ts_if.ts_data, 32'h3333);
    check("t4_overflow", ts_if.ts_overflow, 1);
    ts_if.ts_ack = 1; step(); ts_if.ts_ack = 0;
    check("t4_ack_valid", ts_if.ts_valid, 0);
    check("t4_ack_ovf", ts_if.ts_overflow, 0);

    // Ack coinciding with a capture while overflowed
    counter = 32'h5555;
    drive(1, 5); drive(0, 5);
    drive(1, 5); drive(0, 5);
    check("t5_pre_ovf", ts_if.ts_overflow, 1);
    drive(1, 5);
    counter = 32'h0000_BEEF;
    trigger_in = 0;
    step(); step();
    ts_if.ts_ack = 1; step(); ts_if.ts_ack = 0;
    check("t5_valid", ts_if.ts_valid, 1);
    check("t5_data", ts_if.ts_data, 32'h0000_BEEF);
    check("t5_ovf", ts_if.ts_overflow, 0);
    drive(0, 3);

    // Reset mid-qualification, then trigger held high through release
    filt_len = 5;
    drive(1, 4);
    rst = 1; step();
    check("t6_level", trig_level, 0);
    check("t6_valid", ts_if.ts_valid, 0);
    check("t6_data", ts_if.ts_data, 0);
    check("t6_pulses", {rise_pulse, fall_pulse, trig_pulse}, 0);
    rst = 0; n = 0;
    do begin
      step();
      n++;
    end while (!rise_pulse && n < 40);
    check("t6_rise_after_rst", n, 8);

    // Randomized traffic, including mid-qualification filt_len changes and resets
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin
        trigger_in = 1'($urandom);
        hold = $urandom_range(1, 20);
      end
      hold--;
      ts_if.ts_ack = ($urandom_range(0, 5) == 0);
      counter = $urandom;
      if ($urandom_range(0, 99) == 0) {en_r, en_f, save_r, save_f} = 4'($urandom);
      if ($urandom_range(0, 149) == 0) filt_len = 4'($urandom_range(0, 15));
      rst = ($urandom_range(0, 399) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
